// File: rtl/video_write_fifo_if.sv
// Write-request bus for the video write FIFO.
// Carries the producer side (the push request from the execute stage and the
// VGA column/row counters) and the consumer side (the video memory write
// port), together with the FIFO status flags.
//   master : environment side. Drives iPush/iAddress/iColor/iColumnCount/iRowCount
//            and observes the status flags and the write port.
//   slave  : FIFO side. The reverse directions.
interface video_write_fifo_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH_LOG2 = 4
);
  logic                  iPush;
  logic [ADDR_WIDTH-1:0] iAddress;
  logic [DATA_WIDTH-1:0] iColor;
  logic [9:0]            iColumnCount;
  logic [9:0]            iRowCount;
  logic                  oFull;
  logic                  oEmpty;
  logic [DEPTH_LOG2:0]   oCount;
  logic                  oOverflow;
  logic                  oWriteEnable;
  logic [ADDR_WIDTH-1:0] oWriteAddress;
  logic [DATA_WIDTH-1:0] oWriteData;

  modport master (
    output iPush, iAddress, iColor, iColumnCount, iRowCount,
    input  oFull, oEmpty, oCount, oOverflow, oWriteEnable, oWriteAddress, oWriteData
  );

  modport slave (
    input  iPush, iAddress, iColor, iColumnCount, iRowCount,
    output oFull, oEmpty, oCount, oOverflow, oWriteEnable, oWriteAddress, oWriteData
  );
endinterface

// File: rtl/video_write_fifo.sv
// Video write FIFO.
// Buffers WVM write requests (address + colour) and commits them to the video
// memory only while the VGA scan is in blanking, so a frame is never shown
// half-updated. One entry is drained per blanking cycle.
// Ports:
//   Clock - system clock, rising edge
//   Reset - synchronous, active-high; empties the FIFO and clears all outputs
//   bus   - video_write_fifo_if.slave: push request, VGA counters, status
//           flags (oFull/oEmpty/oCount/oOverflow) and the registered video
//           memory write port (oWriteEnable/oWriteAddress/oWriteData)
module video_write_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 3,
  parameter int H_VISIBLE     = 640,
  parameter int V_VISIBLE     = 480,
  parameter int DRAIN_ANYTIME = 0
) (
  input  logic Clock,
  input  logic Reset,
  video_write_fifo_if.slave bus
);
  localparam int unsigned         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [9:0]          LP_H    = 10'(H_VISIBLE);
  localparam logic [9:0]          LP_V    = 10'(V_VISIBLE);

  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic w_full;
  logic w_empty;
  logic w_blank;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  always_comb begin
    w_full    = (r_count == LP_FULL);
    w_empty   = (r_count == '0);
    w_blank   = (DRAIN_ANYTIME != 0) || (bus.iColumnCount >= LP_H) || (bus.iRowCount >= LP_V);
    w_pop     = !w_empty && w_blank;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    w_push_ok = bus.iPush && (!w_full || w_pop);
    w_drop    = bus.iPush && w_full && !w_pop;
  end

  // Storage has no reset; only entries behind the pointers are ever read.
  always_ff @(posedge Clock) begin
    if (w_push_ok) begin
      r_mem_addr[r_wr_ptr] <= bus.iAddress;
      r_mem_data[r_wr_ptr] <= bus.iColor;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_waddr  <= r_mem_addr[r_rd_ptr];
        r_wdata  <= r_mem_data[r_rd_ptr];
      end
      r_we <= w_pop;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    bus.oFull         = w_full;
    bus.oEmpty        = w_empty;
    bus.oCount        = r_count;
    bus.oOverflow     = r_overflow;
    bus.oWriteEnable  = r_we;
    bus.oWriteAddress = r_waddr;
    bus.oWriteData    = r_wdata;
  end
endmodule
